// File: rtl/if_stage.sv
// if_stage: PC, imem request/grant/response, 2-entry {ins, pc} FIFO to decode.
// Optional macro IF_MISALIGN_CHK_EN: misaligned redirect target halts fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      pc;
  logic [1:0]       outs;
  logic [1:0]       drop;
  logic [1:0]       cnt;
  logic [1:0]       iq_cnt;
  logic [1:0][31:0] f_ins;
  logic [1:0][31:0] f_pc;
  logic [1:0][31:0] iq;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             halted;
  logic             pop;
  logic             fire;
  logic             resp;
  logic             push;
  logic             bad;
  logic             iq_idx;
  logic [2:0]       occ;
  logic [1:0]       outs_nxt;
  logic [31:0]      tgt;

  assign if_valid_o = (cnt != 2'd0);
  assign ins_o = if_valid_o ? f_ins[rd_ptr] : NOP;
  assign pc_o  = if_valid_o ? f_pc[rd_ptr] : 32'h0;

  assign pop = if_valid_o & id_ready_i & ~redirect_i;
  assign occ = {1'b0, cnt} + {1'b0, outs} - {2'b00, pop};

  assign imem_req_o  = rst & ~halted & ~redirect_i & (occ < 3'd2);
  assign imem_addr_o = pc;

  assign fire = imem_req_o & imem_gnt_i;
  // a response with nothing in flight is a stray and is ignored
  assign resp = imem_rvalid_i & (outs != 2'd0);
  assign push = resp & (drop == 2'd0) & ~redirect_i;
  assign outs_nxt = outs + {1'b0, fire} - {1'b0, resp};

  // slot for a new in-flight pc: iq_cnt - push, always 0 or 1 when fire
  assign iq_idx = iq_cnt[0] ^ push;

`ifdef IF_MISALIGN_CHK_EN
  assign bad = redirect_i & (redirect_pc_i[1:0] != 2'b00);
  assign tgt = redirect_pc_i;
  assign misalign_o = halted;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc_i[1:0];
  assign bad = 1'b0;
  assign tgt = {redirect_pc_i[31:2], 2'b00};
  assign misalign_o = 1'b0;
`endif

  // control state: pc, credits, drop count, FIFO pointers, halt flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= RESET_PC;
      outs   <= 2'd0;
      drop   <= 2'd0;
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      iq_cnt <= 2'd0;
      halted <= 1'b0;
    end else begin
      outs <= outs_nxt;
      if (bad) halted <= 1'b1;
      if (redirect_i) begin
        pc     <= tgt;
        drop   <= outs_nxt;
        cnt    <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        iq_cnt <= 2'd0;
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (resp && drop != 2'd0) drop <= drop - 2'd1;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
        if (push) wr_ptr <= ~wr_ptr;
        if (pop) rd_ptr <= ~rd_ptr;
        iq_cnt <= iq_cnt + {1'b0, fire} - {1'b0, push};
      end
    end
  end

  // datapath: FIFO payload and in-flight pc shift queue
  always_ff @(posedge clk) begin
    if (push) begin
      f_ins[wr_ptr] <= imem_rdata_i;
      f_pc[wr_ptr]  <= iq[0];
      iq[0]         <= iq[1];
    end
    if (fire) iq[iq_idx] <= pc;
  end

endmodule
